// File: rtl/prio_enc_pkg.sv
// Shared definitions for the registered priority-encoder arbiter:
// mode encodings and the FSM state type.
package prio_enc_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/prio_pick.sv
// Combinational pick: fixed priority (highest or lowest index wins) or
// round-robin scan starting at ptr and wrapping N-1 -> 0.
module prio_pick #(
  parameter  int N         = 4,
  parameter  bit HIGH_WINS = 1'b1,
  localparam int W         = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         mode,
  output logic [W-1:0] code,
  output logic [N-1:0] onehot,
  output logic         any
);
  import prio_enc_pkg::*;

  logic w_found;

  always_comb begin
    code    = '0;
    onehot  = '0;
    any     = |req;
    w_found = 1'b0;
    if (mode == MODE_RR) begin
      // First set bit at or after ptr, modulo N, wins.
      for (int k = 0; k < N; k++) begin
        if (!w_found && req[(int'(ptr) + k) % N]) begin
          w_found = 1'b1;
          code    = W'((int'(ptr) + k) % N);
          onehot[(int'(ptr) + k) % N] = 1'b1;
        end
      end
    end else if (HIGH_WINS) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          code      = W'(i);
          onehot    = '0;
          onehot[i] = 1'b1;
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) begin
          code      = W'(i);
          onehot    = '0;
          onehot[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prio_enc_arb.sv
// Registered N-input priority encoder / arbiter. Each pick is held as a token
// behind a valid/ready handshake; the round-robin pointer advances on accept.
module prio_enc_arb #(
  parameter  int N         = 4,
  parameter  bit HIGH_WINS = 1'b1,
  localparam int W         = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  input  logic         mode_i,
  input  logic         out_ready_i,
  output logic         valid_o,
  output logic [W-1:0] code_o,
  output logic [N-1:0] onehot_o,
  output logic [W-1:0] rr_ptr_o
);
  import prio_enc_pkg::*;

  // Handshake: a result transfers on any edge where valid_o & out_ready_i.
  // While valid_o = 1 and out_ready_i = 0, code_o/onehot_o/valid_o are frozen;
  // out_ready_i is ignored while valid_o = 0.

  state_e       r_state, w_state_nxt;
  logic         r_valid, w_valid_nxt;
  logic [W-1:0] r_code;
  logic [N-1:0] r_onehot;
  logic [W-1:0] r_ptr, w_ptr_nxt, w_ptr_inc, w_pick_ptr;
  logic         w_accept, w_load;
  logic [W-1:0] w_code;
  logic [N-1:0] w_onehot;
  logic         w_any;

  assign w_accept   = r_valid & out_ready_i;
  assign w_ptr_inc  = (r_code == W'(N - 1)) ? '0 : r_code + 1'b1;
  // A back-to-back pick must already see the pointer moved past the accepted code.
  assign w_pick_ptr = w_accept ? w_ptr_inc : r_ptr;

  prio_pick #(
    .N         (N),
    .HIGH_WINS (HIGH_WINS)
  ) u_pick (
    .req    (req_i),
    .ptr    (w_pick_ptr),
    .mode   (mode_i),
    .code   (w_code),
    .onehot (w_onehot),
    .any    (w_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_ptr_nxt   = r_ptr;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_load      = 1'b1;
          w_valid_nxt = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (w_accept) begin
          w_ptr_nxt = w_ptr_inc;
          if (w_any) begin
            w_load = 1'b1;
          end else begin
            w_valid_nxt = 1'b0;
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_valid  <= 1'b0;
      r_code   <= '0;
      r_onehot <= '0;
      r_ptr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      r_ptr   <= w_ptr_nxt;
      if (w_load) begin
        r_code   <= w_code;
        r_onehot <= w_onehot;
      end
    end
  end

  assign valid_o  = r_valid;
  assign code_o   = r_code;
  assign onehot_o = r_onehot;
  assign rr_ptr_o = r_ptr;

endmodule
